// File: rtl/genesys_pc_pkg.sv
// Shared definitions for the performance-counter dump engine.
// Holds the dump FSM state encoding and the AXI write-response codes
// used to classify the B-channel result.
package genesys_pc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } pc_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/perf_counter_dump_if.sv
// AXI write-channel bundle (AW, W, B) between the counter dump engine and
// the memory-side slave.
//   master : driven by perf_counter_dump (awaddr/awlen/awvalid, wdata/wvalid/
//            wlast, bready); receives awready, wready, bvalid, bresp.
//   slave  : the mirror view for the memory side.
interface perf_counter_dump_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 512
);

  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [7:0]                axi_awlen;
  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [AXI_DATA_WIDTH-1:0] axi_wdata;
  logic                      axi_wvalid;
  logic                      axi_wlast;
  logic                      axi_wready;
  logic                      axi_bvalid;
  logic [1:0]                axi_bresp;
  logic                      axi_bready;

  modport master (
    output axi_awaddr, axi_awlen, axi_awvalid,
    output axi_wdata, axi_wvalid, axi_wlast,
    output axi_bready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_wdata, axi_wvalid, axi_wlast,
    input  axi_bready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

endinterface

// File: rtl/pc_beat_sel.sv
// Beat selector for the counter dump.
//   mask     : groups selected for the dump
//   cur_idx  : search start; the lowest set mask bit at index >= cur_idx wins
//   next_idx : index of that bit (0 when none)
//   last     : no further set bit above next_idx
//   count    : popcount of mask
module pc_beat_sel #(
  parameter int unsigned NUM_BEATS = 6,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [NUM_BEATS-1:0] mask,
  input  logic [IDX_W-1:0]     cur_idx,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 last,
  output logic [IDX_W-1:0]     count
);

  logic found;

  always_comb begin
    next_idx = '0;
    last     = 1'b1;
    count    = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      if (mask[i]) begin
        count = count + IDX_W'(1);
        if (IDX_W'(i) >= cur_idx) begin
          if (!found) begin
            next_idx = IDX_W'(i);
            found    = 1'b1;
          end else begin
            last = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_dump.sv
// Performance-counter dump engine: on a pc_start accepted in IDLE, snapshots
// the counter groups, base address and beat mask, then writes the selected
// groups as one AXI burst (one beat per group, ascending index).
//   clk, reset          : clock, asynchronous active-high reset
//   pc_start            : single-cycle dump request (ignored unless idle)
//   pc_base_addr        : burst byte address
//   pc_beat_mask        : bit i selects counter group i
//   pc_counters         : flat groups, group i at [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
//   axi                 : AXI AW/W/B master port
//   pc_busy/pc_done     : busy while not idle / one-cycle completion pulse
//   pc_error            : sticky non-OKAY bresp of the last dump
module perf_counter_dump
  import genesys_pc_pkg::*;
#(
  parameter int unsigned PC_DATA_WIDTH  = 64,
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned NUM_BEATS      = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pc_start,
  input  logic [AXI_ADDR_WIDTH-1:0]           pc_base_addr,
  input  logic [NUM_BEATS-1:0]                pc_beat_mask,
  input  logic [NUM_BEATS*AXI_DATA_WIDTH-1:0] pc_counters,
  perf_counter_dump_if.master                 axi,
  output logic                                pc_busy,
  output logic                                pc_done,
  output logic                                pc_error
);

  // Wide enough to hold NUM_BEATS itself, so idx_q + 1 never wraps.
  localparam int unsigned IDX_W = $clog2(NUM_BEATS + 1);

  if ((AXI_DATA_WIDTH % PC_DATA_WIDTH) != 0 || NUM_BEATS < 1 || NUM_BEATS > 16) begin : g_bad_params
    $error("perf_counter_dump: illegal parameter combination");
  end

  pc_state_e                         state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [NUM_BEATS-1:0]              mask_q, mask_d;
  logic [NUM_BEATS*AXI_DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [7:0]                        awlen_q, awlen_d;
  logic                              awvalid_q, awvalid_d;
  logic [AXI_DATA_WIDTH-1:0]         wdata_q, wdata_d;
  logic                              wvalid_q, wvalid_d;
  logic                              wlast_q, wlast_d;
  logic                              bready_q, bready_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              error_q, error_d;

  logic [NUM_BEATS-1:0]      sel_mask;
  logic [IDX_W-1:0]          sel_from;
  logic [IDX_W-1:0]          sel_next;
  logic                      sel_last;
  logic [IDX_W-1:0]          sel_count;
  logic [AXI_DATA_WIDTH-1:0] sel_grp;

  // In IDLE the live mask is used so awlen can be registered on acceptance;
  // afterwards only the snapshot is consulted.
  assign sel_mask = (state_q == ST_IDLE) ? pc_beat_mask : mask_q;
  assign sel_from = (state_q == ST_DATA) ? idx_q + IDX_W'(1) : '0;

  pc_beat_sel #(
    .NUM_BEATS (NUM_BEATS),
    .IDX_W     (IDX_W)
  ) u_beat_sel (
    .mask     (sel_mask),
    .cur_idx  (sel_from),
    .next_idx (sel_next),
    .last     (sel_last),
    .count    (sel_count)
  );

  always_comb begin
    sel_grp = '0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      if (sel_next == IDX_W'(i)) sel_grp = cnt_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_start) begin
          addr_d  = pc_base_addr;
          mask_d  = pc_beat_mask;
          cnt_d   = pc_counters;
          idx_d   = '0;
          error_d = 1'b0;
          if (pc_beat_mask != '0) begin
            state_d   = ST_ADDR;
            awvalid_d = 1'b1;
            awlen_d   = 8'(sel_count) - 8'd1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (axi.axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_DATA;
          wvalid_d  = 1'b1;
          wdata_d   = sel_grp;
          wlast_d   = sel_last;
          idx_d     = sel_next;
        end
      end
      ST_DATA: begin
        if (axi.axi_wready) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            wdata_d = sel_grp;
            wlast_d = sel_last;
            idx_d   = sel_next;
          end
        end
      end
      ST_RESP: begin
        if (axi.axi_bvalid) begin
          bready_d = 1'b0;
          error_d  = (axi.axi_bresp != AXI_RESP_OKAY);
          state_d  = ST_DONE;
          done_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awlen   = awlen_q;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_wlast   = wlast_q;
  assign axi.axi_bready  = bready_q;
  assign pc_busy         = busy_q;
  assign pc_done         = done_q;
  assign pc_error        = error_q;

endmodule

// File: tb/tb_perf_counter_dump.sv
// Directed self-checking bench for perf_counter_dump (default parameters).
module tb_perf_counter_dump;
  import genesys_pc_pkg::*;

  logic          clk;
  logic          reset;
  logic          pc_start;
  logic [63:0]   pc_base_addr;
  logic [5:0]    pc_beat_mask;
  logic [3071:0] pc_counters;
  logic          pc_busy;
  logic          pc_done;
  logic          pc_error;

  int n_tests = 0;
  int n_fail  = 0;

  perf_counter_dump_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(512)) axi_if ();

  perf_counter_dump #(
    .PC_DATA_WIDTH  (64),
    .AXI_DATA_WIDTH (512),
    .AXI_ADDR_WIDTH (64),
    .NUM_BEATS      (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_start     (pc_start),
    .pc_base_addr (pc_base_addr),
    .pc_beat_mask (pc_beat_mask),
    .pc_counters  (pc_counters),
    .axi          (axi_if),
    .pc_busy      (pc_busy),
    .pc_done      (pc_done),
    .pc_error     (pc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] grp(input int unsigned seed, input int unsigned g);
    logic [511:0] v;
    for (int unsigned k = 0; k < 8; k++)
      v[k*64 +: 64] = {32'hC0DE0000 + seed, g * 32'h01010101 + k};
    return v;
  endfunction

  function automatic logic [3071:0] counters(input int unsigned seed);
    logic [3071:0] v;
    for (int unsigned g = 0; g < 6; g++) v[g*512 +: 512] = grp(seed, g);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input string tag, input logic [5:0] mask, input logic [63:0] base,
                          input int unsigned seed, input bit toggle, input logic [1:0] bresp_v,
                          input bit churn);
    int           exp_idx[$];
    int           exp_n;
    int           exp_lat;
    int           nbeat       = 0;
    int           aw_seen     = 0;
    int           busy_cycles = 0;
    int           done_cycle  = -1;
    bit           prev_stall  = 1'b0;
    logic [511:0] prev_data   = '0;
    for (int g = 0; g < 6; g++) if (mask[g]) exp_idx.push_back(g);
    exp_n   = exp_idx.size();
    exp_lat = (exp_n == 0) ? 1 : exp_n + 3;

    pc_start               = 1'b1;
    pc_base_addr           = base;
    pc_beat_mask           = mask;
    pc_counters            = counters(seed);
    axi_if.axi_awready     = 1'b1;
    axi_if.axi_wready      = 1'b1;
    axi_if.axi_bvalid      = 1'b1;
    axi_if.axi_bresp       = bresp_v;
    step();
    pc_start = 1'b0;

    for (int cyc = 1; cyc <= 60 && done_cycle < 0; cyc++) begin
      if (churn) begin
        pc_counters  = counters(seed + 100 + cyc);
        pc_base_addr = ~base;
        pc_beat_mask = ~mask;
      end
      if (toggle) axi_if.axi_wready = cyc[0];
      if (cyc == 1) chk({tag, "_err_clear"}, pc_error, 0);
      if (pc_busy) busy_cycles++;
      if (axi_if.axi_awvalid) begin
        aw_seen++;
        chk({tag, "_awaddr"}, axi_if.axi_awaddr, base);
        chk({tag, "_awlen"}, axi_if.axi_awlen, exp_n - 1);
      end
      if (axi_if.axi_wvalid) begin
        if (prev_stall) chk({tag, "_stall_hold"}, axi_if.axi_wdata, prev_data);
        if (axi_if.axi_wready) begin
          if (nbeat < exp_n) begin
            chk({tag, "_wdata"}, axi_if.axi_wdata, grp(seed, exp_idx[nbeat]));
            chk({tag, "_wlast"}, axi_if.axi_wlast, (nbeat == exp_n - 1));
          end else begin
            chk({tag, "_extra_beat"}, nbeat, exp_n);
          end
          nbeat++;
        end
        prev_stall = !axi_if.axi_wready;
        prev_data  = axi_if.axi_wdata;
      end else begin
        prev_stall = 1'b0;
      end
      if (pc_done) done_cycle = cyc;
      else step();
    end

    if (toggle) chk({tag, "_done_seen"}, (done_cycle > 0), 1);
    else        chk({tag, "_latency"}, done_cycle, exp_lat);
    chk({tag, "_beats"}, nbeat, exp_n);
    chk({tag, "_aw_count"}, aw_seen, (exp_n == 0) ? 0 : 1);
    chk({tag, "_busy_cycles"}, busy_cycles, done_cycle);
    chk({tag, "_error"}, pc_error, (bresp_v != AXI_RESP_OKAY));

    // A start presented during DONE must be dropped.
    pc_start = 1'b1;
    step();
    pc_start = 1'b0;
    chk({tag, "_done_pulse"}, pc_done, 0);
    chk({tag, "_idle_busy"}, pc_busy, 0);
    chk({tag, "_start_in_done"}, axi_if.axi_awvalid, 0);
    chk({tag, "_error_sticky"}, pc_error, (bresp_v != AXI_RESP_OKAY));
    step();
    chk({tag, "_no_queue"}, pc_busy, 0);
  endtask

  initial begin
    reset              = 1'b1;
    pc_start           = 1'b0;
    pc_base_addr       = '0;
    pc_beat_mask       = '0;
    pc_counters        = '0;
    axi_if.axi_awready = 1'b0;
    axi_if.axi_wready  = 1'b0;
    axi_if.axi_bvalid  = 1'b0;
    axi_if.axi_bresp   = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", pc_busy, 0);
    chk("rst_done", pc_done, 0);
    chk("rst_error", pc_error, 0);
    chk("rst_awvalid", axi_if.axi_awvalid, 0);
    chk("rst_wvalid", axi_if.axi_wvalid, 0);
    chk("rst_bready", axi_if.axi_bready, 0);
    chk("rst_awaddr", axi_if.axi_awaddr, 0);
    reset = 1'b0;
    step();

    run_dump("full",   6'b111111, 64'h0000_0000_8000_0000, 1, 1'b0, AXI_RESP_OKAY,   1'b0);
    run_dump("sparse", 6'b100101, 64'h0000_0001_0000_0040, 2, 1'b1, AXI_RESP_OKAY,   1'b0);
    run_dump("zero",   6'b000000, 64'h0000_0000_0000_1000, 3, 1'b0, AXI_RESP_OKAY,   1'b0);
    run_dump("churn",  6'b011010, 64'hDEAD_BEEF_0000_0100, 4, 1'b0, AXI_RESP_SLVERR, 1'b1);
    run_dump("single", 6'b000001, 64'h0000_0000_0000_2000, 5, 1'b0, AXI_RESP_OKAY,   1'b0);

    // Second start during DATA is dropped; reset mid-burst aborts at once.
    pc_start           = 1'b1;
    pc_base_addr       = 64'h0000_0000_0000_3000;
    pc_beat_mask       = 6'b111111;
    pc_counters        = counters(7);
    axi_if.axi_awready = 1'b1;
    axi_if.axi_wready  = 1'b0;
    axi_if.axi_bvalid  = 1'b0;
    step();
    pc_start = 1'b0;
    step();
    chk("mid_wvalid", axi_if.axi_wvalid, 1);
    chk("mid_wdata0", axi_if.axi_wdata, grp(7, 0));
    pc_start          = 1'b1;
    pc_base_addr      = 64'h0000_0000_0000_FFFF;
    pc_beat_mask      = 6'b000001;
    axi_if.axi_wready = 1'b1;
    step();
    pc_start = 1'b0;
    chk("mid_ignored_aw", axi_if.axi_awvalid, 0);
    chk("mid_wdata1", axi_if.axi_wdata, grp(7, 1));
    chk("mid_busy", pc_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", pc_busy, 0);
    chk("abort_wvalid", axi_if.axi_wvalid, 0);
    chk("abort_wdata", axi_if.axi_wdata, 0);
    chk("abort_awaddr", axi_if.axi_awaddr, 0);
    chk("abort_done", pc_done, 0);
    chk("abort_bready", axi_if.axi_bready, 0);
    #3;
    reset = 1'b0;
    step();
    chk("post_rst_busy", pc_busy, 0);
    chk("post_rst_awvalid", axi_if.axi_awvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_dump.md
PERF_COUNTER_DUMP -- requirements
Module: perf_counter_dump

Interface
REQ-001 SHALL have parameter PC_DATA_WIDTH, default 64, width of one counter.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 512, write-data beat width; SHALL be an integer multiple of PC_DATA_WIDTH.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-004 SHALL have parameter NUM_BEATS, default 6, counter groups (one AXI beat each); legal range 1..16.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pc_start  in  1  single-cycle dump request.
REQ-008 pc_base_addr  in  AXI_ADDR_WIDTH  destination byte address, sampled on accepted start.
REQ-009 pc_beat_mask  in  NUM_BEATS  bit i=1 includes group i in dump, sampled on accepted start.
REQ-010 pc_counters  in  NUM_BEATS*AXI_DATA_WIDTH  flat counter groups, group i at bits [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
REQ-011 axi_awaddr  out  AXI_ADDR_WIDTH; axi_awlen  out  8; axi_awvalid  out  1; axi_awready  in  1.
REQ-012 axi_wdata  out  AXI_DATA_WIDTH; axi_wvalid  out  1; axi_wlast  out  1; axi_wready  in  1.
REQ-013 axi_bvalid  in  1; axi_bresp  in  2; axi_bready  out  1.
REQ-014 pc_busy  out  1  high whenever state is not IDLE.
REQ-015 pc_done  out  1  one-cycle pulse at dump completion.
REQ-016 pc_error  out  1  sticky: last dump received non-zero bresp; cleared on next accepted start.

Function
REQ-017 States SHALL be IDLE, ADDR, DATA, RESP, DONE.
REQ-018 pc_start in IDLE SHALL be accepted; pc_start in any other state SHALL be ignored without queuing.
REQ-019 On acceptance, pc_counters, pc_base_addr and pc_beat_mask SHALL be snapshotted into registers; later input changes SHALL not affect the dump.
REQ-020 Accepted start with non-zero mask SHALL go to ADDR next cycle; with zero mask SHALL go directly to DONE, issuing no AXI traffic.
REQ-021 ADDR: axi_awvalid=1, axi_awaddr=snapshot address, axi_awlen=popcount(mask)-1, all stable until the cycle axi_awready=1, then DATA.
REQ-022 DATA: axi_wvalid=1, axi_wdata=snapshot group of lowest not-yet-sent mask bit, ascending index; held stable until axi_wready=1, then advances to next set bit.
REQ-023 axi_wlast SHALL be 1 exactly while the final selected group is presented; wready on that beat SHALL transition to RESP.
REQ-024 RESP: axi_bready=1; on axi_bvalid=1 latch pc_error=(axi_bresp!=0), go to DONE.
REQ-025 DONE: pc_done=1 for exactly one cycle, then IDLE; pc_start in DONE SHALL be ignored.
REQ-026 axi_wvalid/axi_wlast SHALL be 0 outside DATA; axi_awvalid 0 outside ADDR; axi_bready 0 outside RESP.
REQ-027 Minimum dump latency (accept to pc_done) with awready, wready, bvalid always high SHALL be popcount(mask)+3 cycles.

Reset
REQ-028 Reset assertion at any time, including mid-burst, SHALL force IDLE immediately, abandoning the transaction.
REQ-029 All outputs SHALL reset to 0; snapshot registers, beat index and pc_error SHALL reset to 0.

Structure
REQ-030 State enum and AXI response codes (OKAY=0) SHALL live in shared package genesys_pc_pkg.
REQ-031 Next-set-bit and popcount logic SHALL be one sub-module pc_beat_sel (inputs mask, current index; outputs next index, last flag, count).

Verification
REQ-032 Defaults, mask=6'b111111, all ready high, bresp=0 -> awlen=5, 6 beats groups 0..5, wlast on beat 6, pc_done 9 cycles after start, pc_error=0.
REQ-033 mask=6'b100101, wready toggling 1/0 -> beats carry groups 0,2,5 only, awlen=2, data stable through stalls, wlast on group 5.
REQ-034 mask=0 -> no awvalid, pc_done 1 cycle after start, pc_busy high exactly 1 cycle.
REQ-035 Change pc_counters each cycle after start, bresp=2'b10 -> beats carry start-cycle values; pc_error=1 after done, cleared on next start.
REQ-036 Second pc_start during DATA, then reset asserted mid-burst -> second start ignored; outputs 0 and pc_busy=0 immediately on reset.
